// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable clock divider with shadowed ratio/mode and glitch-free updates
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module clk_div_prog #(
   parameter int WIDTH = `DATA_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] div_ratio,
   input  logic             mode,
   output logic             clk_out,
   output logic             tick,
   output logic [WIDTH-1:0] cnt,
   output logic             pending
);

   // Active ratio/mode drive the counter; shadow copies wait for the next wrap.
   logic [WIDTH-1:0] na_q, na_d;
   logic [WIDTH-1:0] ns_q, ns_d;
   logic             ma_q, ma_d;
   logic             ms_q, ms_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             pending_q, pending_d;

   logic             running;
   logic             wrap;
   logic [WIDTH-1:0] high_len;

   assign running = (na_q != '0);
   assign wrap    = en && running && (cnt_q == na_q - WIDTH'(1));

   // Next-state: ratio changes only take effect at a period boundary, or at once when stopped.
   always_comb begin
      na_d      = na_q;
      ns_d      = ns_q;
      ma_d      = ma_q;
      ms_d      = ms_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;

      if (!running) begin
         // Stopped: nothing in progress to protect, so a load applies immediately even with en low.
         cnt_d = '0;
         if (load) begin
            na_d      = div_ratio;
            ma_d      = mode;
            ns_d      = div_ratio;
            ms_d      = mode;
            pending_d = 1'b0;
         end
      end else if (wrap) begin
         // Period boundary: a coincident load beats an older pending shadow.
         cnt_d     = '0;
         pending_d = 1'b0;
         if (load) begin
            na_d = div_ratio;
            ma_d = mode;
            ns_d = div_ratio;
            ms_d = mode;
         end else if (pending_q) begin
            na_d = ns_q;
            ma_d = ms_q;
         end
      end else begin
         if (en) begin
            cnt_d = cnt_q + WIDTH'(1);
         end
         if (load) begin
            ns_d      = div_ratio;
            ms_d      = mode;
            pending_d = 1'b1;
         end
      end
   end

   // High phase is ceil(N/2) in square mode, a single cycle in pulse mode.
   always_comb begin
      high_len = ma_d ? WIDTH'(1) : ((na_d >> 1) + WIDTH'(na_d[0]));
      clk_out_d = (na_d != '0) && (cnt_d < high_len);
      tick_d    = (na_d != '0) && (cnt_d == '0);
   end

   // State and output registers; reset overrides load and en.
   always_ff @(posedge clk) begin
      if (!reset) begin
         na_q      <= '0;
         ns_q      <= '0;
         ma_q      <= 1'b0;
         ms_q      <= 1'b0;
         cnt_q     <= '0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         na_q      <= na_d;
         ns_q      <= ns_d;
         ma_q      <= ma_d;
         ms_q      <= ms_d;
         cnt_q     <= cnt_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
         pending_q <= pending_d;
      end
   end

   assign clk_out = clk_out_q;
   assign tick    = tick_q;
   assign cnt     = cnt_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - scoreboard bench for clk_div_prog
module tb_clk_div_prog;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic [7:0] div_ratio = '0;
   logic       mode = 1'b0;
   logic       clk_out;
   logic       tick;
   logic [7:0] cnt;
   logic       pending;

   clk_div_prog #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .load      (load),
      .div_ratio (div_ratio),
      .mode      (mode),
      .clk_out   (clk_out),
      .tick      (tick),
      .cnt       (cnt),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       clk_out;
      logic       tick;
      logic       pending;
      logic [7:0] cnt;
      string      tag;
   } exp_t;

   exp_t sb[$];

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   int m_na = 0, m_ns = 0, m_ma = 0, m_ms = 0, m_cnt = 0, m_pend = 0;

   logic [7:0] clk_pat;
   logic [7:0] tick_pat;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic r, input logic e, input logic l, input int d, input int m);
      if (!r) begin
         m_na = 0; m_ns = 0; m_ma = 0; m_ms = 0; m_cnt = 0; m_pend = 0;
      end else if (m_na == 0) begin
         m_cnt = 0;
         if (l) begin
            m_na = d; m_ma = m; m_ns = d; m_ms = m; m_pend = 0;
         end
      end else if (e && m_cnt == m_na - 1) begin
         m_cnt  = 0;
         if (l) begin
            m_na = d; m_ma = m; m_ns = d; m_ms = m;
         end else if (m_pend != 0) begin
            m_na = m_ns; m_ma = m_ms;
         end
         m_pend = 0;
      end else begin
         if (e) m_cnt = m_cnt + 1;
         if (l) begin
            m_ns = d; m_ms = m; m_pend = 1;
         end
      end
   endtask

   task automatic step(input logic r, input logic e, input logic l, input int d, input int m,
                       input string tag);
      exp_t x;
      exp_t got;
      int   h;
      reset     = r;
      en        = e;
      load      = l;
      div_ratio = d[7:0];
      mode      = m[0];
      model(r, e, l, d, m);
      h = (m_ma != 0) ? 1 : (m_na + 1) / 2;
      x.clk_out = (m_na >= 1) && (m_cnt < h);
      x.tick    = (m_na >= 1) && (m_cnt == 0);
      x.pending = (m_pend != 0);
      x.cnt     = m_cnt[7:0];
      x.tag     = tag;
      sb.push_back(x);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk({got.tag, ".clk_out"}, {31'd0, clk_out}, {31'd0, got.clk_out});
      chk({got.tag, ".tick"},    {31'd0, tick},    {31'd0, got.tick});
      chk({got.tag, ".pending"}, {31'd0, pending}, {31'd0, got.pending});
      chk({got.tag, ".cnt"},     {24'd0, cnt},     {24'd0, got.cnt});
      clk_pat  = {clk_pat[6:0], clk_out};
      tick_pat = {tick_pat[6:0], tick};
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 0, 0, tag);
   endtask

   task automatic run_to(input int target, input string tag);
      for (int i = 0; i < 64 && m_cnt != target; i++) step(1'b1, 1'b1, 1'b0, 0, 0, tag);
      chk({tag, ".reach"}, {24'd0, cnt}, target);
   endtask

   initial begin
      // Reset and stopped state
      step(1'b0, 1'b0, 1'b0, 0, 0, "rst0");
      step(1'b0, 1'b1, 1'b1, 7, 1, "rst1");
      idle(3, "stopped");

      // N=4 square
      step(1'b1, 1'b1, 1'b1, 4, 0, "ld4");
      idle(7, "n4");
      chk("n4.clk_pattern", {24'd0, clk_pat}, 32'h0000_00CC);
      chk("n4.tick_pattern", {24'd0, tick_pat}, 32'h0000_0088);
      idle(4, "n4b");

      // N=5 square, then switch to pulse mid-period
      run_to(1, "to1");
      step(1'b1, 1'b1, 1'b1, 5, 0, "ld5sq");
      idle(12, "n5sq");
      run_to(1, "n5mid");
      step(1'b1, 1'b1, 1'b1, 5, 1, "ld5pl");
      chk("n5pl.pending", {31'd0, pending}, 32'd1);
      idle(13, "n5pl");

      // N=6, overwrite shadow twice within one period
      step(1'b1, 1'b1, 1'b1, 6, 0, "ld6");
      run_to(0, "n6start");
      run_to(2, "n6c2");
      step(1'b1, 1'b1, 1'b1, 3, 0, "ld3");
      run_to(4, "n6c4");
      step(1'b1, 1'b1, 1'b1, 2, 0, "ld2");
      chk("n6.cnt_before_wrap", {24'd0, cnt}, 32'd5);
      idle(8, "n2");

      // N=4 with a 5-cycle freeze at cnt=1
      step(1'b1, 1'b1, 1'b1, 4, 0, "ld4b");
      run_to(0, "n4bstart");
      run_to(1, "n4bc1");
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 0, 0, "freeze");
      chk("freeze.cnt", {24'd0, cnt}, 32'd1);
      chk("freeze.clk_out", {31'd0, clk_out}, 32'd1);
      step(1'b1, 1'b0, 1'b1, 3, 1, "freeze_ld");
      idle(9, "resume");

      // N=1 then N=0
      run_to(0, "to0");
      step(1'b1, 1'b1, 1'b1, 1, 1, "ld1");
      idle(5, "n1");
      step(1'b1, 1'b1, 1'b1, 0, 0, "ld0");
      idle(4, "n0");
      chk("n0.clk_out", {31'd0, clk_out}, 32'd0);

      // Load while stopped with en low applies immediately
      step(1'b1, 1'b0, 1'b1, 3, 0, "ld3_en0");
      chk("ld3_en0.tick", {31'd0, tick}, 32'd1);
      idle(6, "n3");

      // N=8, reset at cnt=3 with coincident load
      step(1'b1, 1'b1, 1'b1, 8, 0, "ld8");
      run_to(0, "n8start");
      run_to(3, "n8c3");
      step(1'b0, 1'b1, 1'b1, 5, 0, "rst_ld");
      idle(4, "after_rst");
      chk("after_rst.cnt", {24'd0, cnt}, 32'd0);
      step(1'b1, 1'b1, 1'b1, 255, 0, "ld255");
      idle(5, "n255");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter: WIDTH, default `DATA_WIDTH, width of ratio and counter.
REQ-002 Port: clk  input  1  system clock; all logic on posedge.
REQ-003 Port: reset  input  1  synchronous, active-low reset.
REQ-004 Port: en  input  1  count enable; 0 freezes counter and outputs.
REQ-005 Port: load  input  1  one-cycle strobe; samples div_ratio and mode.
REQ-006 Port: div_ratio  input  WIDTH  requested output period N in clk cycles.
REQ-007 Port: mode  input  1  0 = square wave, 1 = single-cycle pulse.
REQ-008 Port: clk_out  output  1  divided clock, registered.
REQ-009 Port: tick  output  1  high in first cycle of every output period, registered.
REQ-010 Port: cnt  output  WIDTH  current phase counter, registered.
REQ-011 Port: pending  output  1  shadow ratio accepted but not yet applied.

Function
REQ-012 Block SHALL hold active ratio Na and mode Ma, plus shadow Ns and Ms.
REQ-013 On load=1, block SHALL capture div_ratio into Ns and mode into Ms, and set pending=1 next cycle.
REQ-014 Load while pending=1 SHALL overwrite the shadow; last load wins, no queueing.
REQ-015 With en=1 and Na>=1, cnt SHALL increment each cycle and wrap from Na-1 to 0.
REQ-016 Shadow SHALL transfer to Na/Ma only at a wrap (cnt==Na-1, en=1); next cycle cnt=0, pending=0.
REQ-017 A load coincident with a wrap SHALL be applied at that wrap; pending stays 0.
REQ-018 If Na==0 (stopped), a load SHALL be applied on the next cycle regardless of en; cnt=0.
REQ-019 Na==0 SHALL hold cnt=0, clk_out=0, tick=0.
REQ-020 High-phase length H SHALL be ceil(Na/2) for Ma=0 and 1 for Ma=1.
REQ-021 In every cycle with Na>=1, clk_out SHALL be 1 iff cnt<H, and tick SHALL be 1 iff cnt==0.
REQ-022 Na==1 SHALL give clk_out constant 1 and tick every cycle in both modes.
REQ-023 Odd Na in square mode SHALL be high ceil(Na/2) cycles, low floor(Na/2) cycles.
REQ-024 clk_out, tick and cnt SHALL be flop outputs with no combinational path from inputs.
REQ-025 en=0 SHALL freeze cnt, clk_out, tick at current values; load still captures into the shadow.
REQ-026 Ratio or mode change SHALL never truncate or extend a period in progress (glitch-free).

Reset
REQ-027 reset=0 at a posedge SHALL force Na=0, Ns=0, Ma=0, Ms=0, cnt=0, clk_out=0, tick=0, pending=0.
REQ-028 reset SHALL dominate load and en in the same cycle.
REQ-029 Reset mid-period SHALL abort immediately; block stays stopped until next load.

Verification
REQ-030 Reset, then load N=4 mode 0, en=1 -> clk_out 1,1,0,0 repeating, tick every 4th cycle, cnt 0..3.
REQ-031 Load N=5 mode 0 -> clk_out high 3, low 2; then load N=5 mode 1 mid-period -> pending=1 until wrap, then 1-high/4-low.
REQ-032 Running N=6, load N=3 at cnt=2 then N=2 at cnt=4 -> one full 6-cycle period completes, then period 2; N=3 never applied.
REQ-033 Running N=4, en=0 for 5 cycles at cnt=1 -> cnt/clk_out frozen at 1/1; resume completes period with 3 more cycles.
REQ-034 Load N=1 -> clk_out stays 1, tick every cycle; load N=0 -> after wrap clk_out=0, tick=0, cnt=0.
REQ-035 Reset asserted at cnt=3 of N=8 with load=1 same cycle -> all outputs 0, pending=0, Na=0 next cycle.
